// File: rtl/core_pkg.sv
// Shared writeback types: register address/data widths and the {rd, data}
// request carried from execution units to the register-file write port.
package core_pkg;

   localparam int REG_AW = 5;
   localparam int DATA_W = 32;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      reg_addr_t rd;
      data_t     data;
   } wb_req_t;

   function automatic logic is_x0(input reg_addr_t a);
      return a == '0;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO holding pending writeback requests.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic [7:0]
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  T                         wdata,
   output T                         rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   T                mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            full;
   logic            do_push;
   logic            do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rptr_q];
   assign count   = cnt_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU has priority over buffered LSU results,
// with a starvation hold on the ALU and a pending-register scoreboard.
module wb_arbiter
   import core_pkg::*;
#(
   parameter int LSU_DEPTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_valid,
   input  reg_addr_t  alu_rd,
   input  data_t      alu_data,
   input  logic       lsu_valid,
   output logic       lsu_ready,
   input  reg_addr_t  lsu_rd,
   input  data_t      lsu_data,
   output logic       alu_hold,
   input  logic       issue_valid,
   input  reg_addr_t  issue_rd,
   input  reg_addr_t  rs1_addr,
   input  reg_addr_t  rs2_addr,
   output logic       rs1_busy,
   output logic       rs2_busy,
   output logic       wb_en,
   output reg_addr_t  wb_addr,
   output data_t      wb_data
);

   localparam int CW = $clog2(LSU_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   wb_req_t          lsu_req;
   wb_req_t          head;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             lsu_push;
   logic             grant_alu;
   logic             grant_lsu;

   logic [SW-1:0]    starve_q, starve_d;
   logic             hold_q, hold_d;
   logic             wb_en_q, wb_en_d;
   reg_addr_t        wb_addr_q, wb_addr_d;
   data_t            wb_data_q, wb_data_d;
   logic [31:0]      busy_q, busy_d;

   assign lsu_ready = (fifo_count < CW'(LSU_DEPTH));
   assign lsu_push  = lsu_valid && lsu_ready && !is_x0(lsu_rd);
   assign lsu_req   = '{rd: lsu_rd, data: lsu_data};

   wb_fifo #(
      .DEPTH (LSU_DEPTH),
      .T     (wb_req_t)
   ) u_lsu_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (lsu_push),
      .pop   (grant_lsu),
      .wdata (lsu_req),
      .rdata (head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // While the hold is up a non-empty head wins even if the ALU misbehaves.
   assign grant_alu = alu_valid && !is_x0(alu_rd) && !(hold_q && !fifo_empty);
   assign grant_lsu = !fifo_empty && !grant_alu;

   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || grant_lsu)
         starve_d = '0;
      else if (starve_q < SW'(STARVE_LIMIT))
         starve_d = starve_q + 1'b1;
      hold_d = (starve_d >= SW'(STARVE_LIMIT));
   end

   always_comb begin
      wb_en_d   = grant_alu || grant_lsu;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      if (grant_alu) begin
         wb_addr_d = alu_rd;
         wb_data_d = alu_data;
      end else if (grant_lsu) begin
         wb_addr_d = head.rd;
         wb_data_d = head.data;
      end
   end

   // Set is applied after clear so a same-edge issue keeps the register pending.
   always_comb begin
      busy_d = busy_q;
      if (wb_en_q)
         busy_d[wb_addr_q] = 1'b0;
      if (issue_valid && !is_x0(issue_rd))
         busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q  <= '0;
         hold_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         busy_q    <= '0;
      end else begin
         starve_q  <= starve_d;
         hold_q    <= hold_d;
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         busy_q    <= busy_d;
      end
   end

   assign alu_hold = hold_q;
   assign wb_en    = wb_en_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;
   assign rs1_busy = !is_x0(rs1_addr) && busy_q[rs1_addr];
   assign rs2_busy = !is_x0(rs2_addr) && busy_q[rs2_addr];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: priority, starvation hold, scoreboard, x0, reset.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        alu_hold;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_busy, rs2_busy;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.LSU_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .alu_hold(alu_hold),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      issue_valid = 0; issue_rd = 0;
   endtask

   task automatic check_wb(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
      check({tag, ".en"}, {31'b0, wb_en}, {31'b0, en});
      check({tag, ".addr"}, {27'b0, wb_addr}, {27'b0, a});
      check({tag, ".data"}, wb_data, d);
   endtask

   initial begin
      rst = 1; rs1_addr = 0; rs2_addr = 0;
      idle();
      tick(); tick();
      check_wb("rst", 0, 0, 0);
      check("rst.hold", {31'b0, alu_hold}, 0);
      check("rst.ready", {31'b0, lsu_ready}, 1);
      rst = 0;
      tick();

      // ALU-only write, then idle keeps address/data
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      tick();
      check_wb("alu", 1, 5, 32'hDEADBEEF);
      idle();
      tick();
      check_wb("alu.idle", 0, 5, 32'hDEADBEEF);

      // ALU/LSU collision
      alu_valid = 1; alu_rd = 3; alu_data = 32'h0000_0333;
      lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h0000_0444;
      check("col.ready0", {31'b0, lsu_ready}, 1);
      tick();
      check_wb("col.c1", 1, 3, 32'h0000_0333);
      check("col.ready1", {31'b0, lsu_ready}, 1);
      idle();
      tick();
      check_wb("col.c2", 1, 4, 32'h0000_0444);
      tick();
      check("col.c3.en", {31'b0, wb_en}, 0);

      // Backpressure and starvation hold
      alu_valid = 1; alu_rd = 1; alu_data = 32'h0000_1000;
      lsu_valid = 1; lsu_rd = 10; lsu_data = 32'h0000_000A;
      tick();                                   // r10 accepted
      check_wb("bp.e0", 1, 1, 32'h0000_1000);
      lsu_rd = 11; lsu_data = 32'h0000_000B;
      tick();                                   // r11 accepted, denial 1
      check("bp.hold1", {31'b0, alu_hold}, 0);
      lsu_rd = 12; lsu_data = 32'h0000_000C;
      check("bp.ready_full", {31'b0, lsu_ready}, 0);
      tick();                                   // denial 2
      tick();                                   // denial 3
      check("bp.hold3", {31'b0, alu_hold}, 0);
      tick();                                   // denial 4
      check("bp.hold4", {31'b0, alu_hold}, 1);
      check("bp.ready_still_full", {31'b0, lsu_ready}, 0);
      tick();                                   // head wins despite alu_valid
      check_wb("bp.r10", 1, 10, 32'h0000_000A);
      check("bp.hold_clr", {31'b0, alu_hold}, 0);
      alu_valid = 0;
      check("bp.ready_free", {31'b0, lsu_ready}, 1);
      tick();                                   // r12 accepted, r11 written
      check_wb("bp.r11", 1, 11, 32'h0000_000B);
      lsu_valid = 0;
      tick();
      check_wb("bp.r12", 1, 12, 32'h0000_000C);
      tick();
      check("bp.drain.en", {31'b0, wb_en}, 0);

      // Scoreboard on x7
      rs1_addr = 7; rs2_addr = 8;
      issue_valid = 1; issue_rd = 7;
      tick();
      idle();
      check("sb.set", {31'b0, rs1_busy}, 1);
      check("sb.rs2", {31'b0, rs2_busy}, 0);
      alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
      tick();
      idle();
      check("sb.wb_cycle", {31'b0, rs1_busy}, 1);
      tick();
      check("sb.cleared", {31'b0, rs1_busy}, 0);
      issue_valid = 1; issue_rd = 7;
      tick();
      idle();
      alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
      tick();
      idle();
      issue_valid = 1; issue_rd = 7;            // reissue on the clearing edge
      tick();
      idle();
      check("sb.set_wins", {31'b0, rs1_busy}, 1);
      tick();
      check("sb.set_wins2", {31'b0, rs1_busy}, 1);

      // x0 handling
      rs1_addr = 0;
      alu_valid = 1; alu_rd = 0; alu_data = 32'hBAD0;
      lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hBAD1;
      issue_valid = 1; issue_rd = 0;
      tick();
      idle();
      check("x0.en", {31'b0, wb_en}, 0);
      check("x0.busy", {31'b0, rs1_busy}, 0);
      check("x0.ready", {31'b0, lsu_ready}, 1);
      tick();
      check("x0.no_enq", {31'b0, wb_en}, 0);

      // Reset mid-run with two buffered LSU results
      rs1_addr = 9;
      alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
      lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h20;
      issue_valid = 1; issue_rd = 9;
      tick();
      issue_valid = 0;
      lsu_rd = 21; lsu_data = 32'h21;
      tick();
      idle();
      check("rr.full", {31'b0, lsu_ready}, 0);
      check("rr.busy_pre", {31'b0, rs1_busy}, 1);
      rst = 1;
      #1;
      check_wb("rr.inrst", 0, 0, 0);
      check("rr.ready", {31'b0, lsu_ready}, 1);
      check("rr.busy", {31'b0, rs1_busy}, 0);
      tick(); tick();
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rr.post%0d", i), {31'b0, wb_en}, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter LSU_DEPTH, default 2: number of entries in the LSU result FIFO (power of two, at least 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive LSU-head denials before an ALU hold is requested.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports alu_valid  in  1, alu_rd  in  5, alu_data  in  32: ALU writeback source, no backpressure.
REQ-006 SHALL have ports lsu_valid  in  1, lsu_ready  out  1, lsu_rd  in  5, lsu_data  in  32: LSU writeback source, valid/ready.
REQ-007 SHALL have port alu_hold  out  1: registered stall request to the ALU stage.
REQ-008 SHALL have ports issue_valid  in  1, issue_rd  in  5: marks a destination register pending.
REQ-009 SHALL have ports rs1_addr, rs2_addr  in  5 and rs1_busy, rs2_busy  out  1: combinational pending lookups.
REQ-010 SHALL have ports wb_en  out  1, wb_addr  out  5, wb_data  out  32: registered drive of the register-file write port.

Function
REQ-011 LSU transfer SHALL occur on a cycle with lsu_valid and lsu_ready both high; lsu_ready SHALL equal (FIFO count < LSU_DEPTH), independent of lsu_valid.
REQ-012 A transfer with lsu_rd = 0 SHALL be accepted and discarded (not enqueued).
REQ-013 Per cycle, grant priority SHALL be: ALU if alu_valid and alu_rd != 0; otherwise LSU FIFO head if non-empty; otherwise none.
REQ-014 The granted entry SHALL appear on wb_en/wb_addr/wb_data after exactly one clock; with no grant, wb_en SHALL be 0 and wb_addr/wb_data SHALL hold their previous values.
REQ-015 An ALU result with alu_rd = 0 SHALL produce no write and no grant.
REQ-016 Enqueue and dequeue in the same cycle SHALL keep count unchanged; pointers SHALL wrap modulo LSU_DEPTH; data SHALL leave in arrival order.
REQ-017 A starvation counter SHALL increment each cycle the FIFO is non-empty and the head is not granted, and SHALL clear when the head is granted or the FIFO is empty.
REQ-018 When the counter reaches STARVE_LIMIT, alu_hold SHALL be 1 from the next cycle until the head is granted; alu_valid asserted while alu_hold = 1 is an environment violation, and the head SHALL still win.
REQ-019 Scoreboard: busy[issue_rd] SHALL be set on the edge after issue_valid with issue_rd != 0.
REQ-020 busy[wb_addr] SHALL be cleared on an edge where wb_en = 1; when the same register is set and cleared on one edge, set SHALL win.
REQ-021 rsN_busy SHALL equal busy[rsN_addr], forced to 0 for address 0.

Reset
REQ-022 While rst = 1: FIFO empty, counter 0, all busy bits 0, wb_en 0, wb_addr 0, wb_data 0, alu_hold 0, lsu_ready 1 (immediately after rst rises).
REQ-023 Assertion of rst mid-operation SHALL drop buffered LSU results and pending busy bits with no write issued.

Structure
REQ-024 Register address width (5), data width (32), and a writeback-request struct {rd, data} SHALL reside in shared package core_pkg.
REQ-025 The LSU FIFO SHALL be a separate sub-module, wb_fifo, parameterised on depth and payload type.

Verification
REQ-026 ALU-only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle 0 -> wb_en=1, wb_addr=5, wb_data=0xDEADBEEF at cycle 1.
REQ-027 Collision: ALU rd=3 and LSU rd=4 valid at cycle 0 -> cycle 1 writes x3, cycle 2 writes x4; lsu_ready remains 1.
REQ-028 Backpressure: ALU busy every cycle, three LSU results offered -> lsu_ready=0 after two accepted, alu_hold=1 after 4 denials, LSU results written in order.
REQ-029 Scoreboard: issue rd=7, then write x7 -> rs1_busy for x7 is 1 after issue and 0 the cycle after wb_en for x7; issuing x7 on the clearing edge keeps it 1.
REQ-030 x0: ALU rd=0 and LSU rd=0 -> no wb_en, FIFO count 0, rs1_busy(0)=0.
REQ-031 Reset mid-run: rst high with FIFO holding 2 entries -> wb_en 0, lsu_ready 1, all busy 0 while rst high; no stale writes after release.
